blwl_config_ctrl: RTL and testbench

BLWL_CONFIG_CTRL -- requirements
Module: blwl_config_ctrl

---
 rtl/blwl_config_ctrl.sv | 120 ++++++++++++
 tb/tb_blwl_config_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/blwl_config_ctrl.sv
// Bit-line / word-line configuration controller.
// Clears the bank, then writes one config word per row: the bit lines are
// driven first, the row's word line pulses for WL_PULSE cycles, and the bit
// lines stay put for one cycle after the word line falls. All outputs are
// registered.
module blwl_config_ctrl #(
  parameter int unsigned ROWS     = 4,
  parameter int unsigned COLS     = 8,
  parameter int unsigned WL_PULSE = 2
) (
  input  logic                     prog_clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [COLS-1:0]          din,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic [COLS-1:0]          bl,
  output logic [ROWS-1:0]          wl,
  output logic                     bank_reset,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(ROWS)-1:0]  row
);

  localparam int unsigned RowW = $clog2(ROWS);
  localparam int unsigned CntW = $clog2(WL_PULSE + 1);

  localparam logic [RowW-1:0] LastRow  = RowW'(ROWS - 1);
  localparam logic [CntW-1:0] PulseLen = CntW'(WL_PULSE);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [ROWS-1:0] WlOne    = ROWS'(1);

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StLoad,
    StSetup,
    StPulse,
    StHold,
    StDone
  } state_e;

  state_e          state;
  logic [CntW-1:0] cnt;

  // Single FSM; each output is loaded with the value of the state being entered.
  always_ff @(posedge prog_clk) begin
    if (!reset_n) begin
      state      <= StIdle;
      cnt        <= '0;
      row        <= '0;
      bl         <= '0;
      wl         <= '0;
      din_ready  <= 1'b0;
      bank_reset <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (start) begin
            state      <= StClr;
            row        <= '0;
            bank_reset <= 1'b1;
            busy       <= 1'b1;
          end
        end
        StClr: begin
          state      <= StLoad;
          bank_reset <= 1'b0;
          din_ready  <= 1'b1;
        end
        StLoad: begin
          if (din_valid) begin
            state     <= StSetup;
            bl        <= din;
            din_ready <= 1'b0;
          end
        end
        StSetup: begin
          // Bit lines have settled for a cycle; raise this row's word line.
          state <= StPulse;
          wl    <= WlOne << row;
          cnt   <= PulseLen;
        end
        StPulse: begin
          if (cnt == CntOne) begin
            state <= StHold;
            wl    <= '0;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CntOne;
          end
        end
        StHold: begin
          bl <= '0;
          if (row == LastRow) begin
            state <= StDone;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state     <= StLoad;
            row       <= row + RowW'(1);
            din_ready <= 1'b1;
          end
        end
        StDone: begin
          // start is deliberately not looked at here.
          state <= StIdle;
          done  <= 1'b0;
          row   <= '0;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blwl_config_ctrl.sv
// Directed bench for blwl_config_ctrl: full bank program, din stall, ignored
// starts, mid-pulse reset, and a short ROWS=2 / WL_PULSE=1 instance.
module tb_blwl_config_ctrl;

  localparam int PhIdle  = 0;
  localparam int PhClr   = 1;
  localparam int PhLoad  = 2;
  localparam int PhSetup = 3;
  localparam int PhPulse = 4;
  localparam int PhHold  = 5;
  localparam int PhDone  = 6;

  logic       prog_clk;
  logic       reset_n;
  logic       start, start2;
  logic [7:0] din, din2;
  logic       din_valid;
  logic       din_ready, din_ready2;
  logic [7:0] bl, bl2;
  logic [3:0] wl;
  logic [1:0] wl2;
  logic       bank_reset, bank_reset2;
  logic       busy, busy2;
  logic       done, done2;
  logic [1:0] row;
  logic [0:0] row2;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 1'b0;

  logic [7:0] words [4] = '{8'hA5, 8'h5A, 8'hFF, 8'h00};

  blwl_config_ctrl #(.ROWS(4), .COLS(8), .WL_PULSE(2)) dut (
    .prog_clk   (prog_clk),
    .reset_n    (reset_n),
    .start      (start),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .bl         (bl),
    .wl         (wl),
    .bank_reset (bank_reset),
    .busy       (busy),
    .done       (done),
    .row        (row)
  );

  blwl_config_ctrl #(.ROWS(2), .COLS(8), .WL_PULSE(1)) dut2 (
    .prog_clk   (prog_clk),
    .reset_n    (reset_n),
    .start      (start2),
    .din        (din2),
    .din_valid  (1'b1),
    .din_ready  (din_ready2),
    .bl         (bl2),
    .wl         (wl2),
    .bank_reset (bank_reset2),
    .busy       (busy2),
    .done       (done2),
    .row        (row2)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge prog_clk);
    #1;
  endtask

  // Expected phase and row for cycle c after start (start sampled ending cycle 0).
  // The LOAD of row srow is stretched by slen stall cycles.
  function automatic void model(input int c, input int nrows, input int ppl, input int srow,
                                input int slen, output int ph, output int r);
    int t;
    ph = PhIdle;
    r  = 0;
    if (c < 1) return;
    if (c == 1) begin
      ph = PhClr;
      return;
    end
    t = 2;
    for (int k = 0; k < nrows; k++) begin
      int ll;
      ll = 1 + ((k == srow) ? slen : 0);
      r  = k;
      if (c < t + ll) begin ph = PhLoad; return; end
      t += ll;
      if (c == t) begin ph = PhSetup; return; end
      t += 1;
      if (c < t + ppl) begin ph = PhPulse; return; end
      t += ppl;
      if (c == t) begin ph = PhHold; return; end
      t += 1;
    end
    if (c == t) ph = PhDone;
    else r = 0;
  endfunction

  // Run one programming sequence on the 4x8 instance and check every output each cycle.
  task automatic run_seq(input int srow, input int slen, input int sp1, input int sp2,
                         input int rst_at, input int ncyc, input int exp_done_at);
    int ph, r, ph2, r2;
    int done_cnt, clr_cnt, done_at;
    done_cnt = 0;
    clr_cnt  = 0;
    done_at  = 0;
    start     = 1'b1;
    din       = 8'h00;
    din_valid = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      step();
      model(c, 4, 2, srow, slen, ph, r);
      model(c + 1, 4, 2, srow, slen, ph2, r2);
      if (rst_at > 0 && c > rst_at) begin
        ph = PhIdle;
        r  = 0;
      end
      start     = (c == sp1) || (c == sp2);
      reset_n   = (c != rst_at);
      din       = words[r];
      din_valid = !(ph == PhLoad && ph2 == PhLoad);
      if (done) begin
        done_cnt++;
        if (done_at == 0) done_at = c;
      end
      if (bank_reset) clr_cnt++;
      check($sformatf("c%0d_bank_reset", c), 32'(bank_reset), 32'(ph == PhClr));
      check($sformatf("c%0d_busy", c), 32'(busy), 32'(ph >= PhClr && ph <= PhHold));
      check($sformatf("c%0d_done", c), 32'(done), 32'(ph == PhDone));
      check($sformatf("c%0d_din_ready", c), 32'(din_ready), 32'(ph == PhLoad));
      check($sformatf("c%0d_wl", c), 32'(wl), (ph == PhPulse) ? (32'd1 << r) : 32'd0);
      check($sformatf("c%0d_bl", c), 32'(bl),
            (ph >= PhSetup && ph <= PhHold) ? 32'(words[r]) : 32'd0);
      check($sformatf("c%0d_row", c), 32'(row), 32'(r));
    end
    start     = 1'b0;
    reset_n   = 1'b1;
    din_valid = 1'b1;
    check("done_pulses", 32'(done_cnt), (rst_at > 0) ? 32'd0 : 32'd1);
    check("bank_reset_pulses", 32'(clr_cnt), 32'd1);
    if (exp_done_at > 0) check("done_cycle", 32'(done_at), 32'(exp_done_at));
  endtask

  // Word line one-hot-or-zero, and bit lines frozen while a word line is high.
  logic [7:0] bl_prev, bl2_prev;
  always @(negedge prog_clk) begin
    if (mon_en) begin
      check("wl_onehot0", 32'($onehot0(wl)), 32'd1);
      check("wl2_onehot0", 32'($onehot0(wl2)), 32'd1);
      if (wl != '0) check("bl_stable", 32'(bl), 32'(bl_prev));
      if (wl2 != '0) check("bl2_stable", 32'(bl2), 32'(bl2_prev));
    end
    bl_prev  = bl;
    bl2_prev = bl2;
  end

  initial begin
    int ph, r, done2_at;
    reset_n   = 1'b0;
    start     = 1'b0;
    start2    = 1'b0;
    din       = 8'h00;
    din2      = 8'h00;
    din_valid = 1'b1;
    step();
    step();
    check("rst_wl", 32'(wl), 32'd0);
    check("rst_bl", 32'(bl), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_row", 32'(row), 32'd0);
    check("rst_din_ready", 32'(din_ready), 32'd0);
    check("rst_bank_reset", 32'(bank_reset), 32'd0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    step();
    step();
    check("idle_busy", 32'(busy), 32'd0);

    // Nominal program: done in cycle 22.
    run_seq(-1, 0, -1, -1, 0, 24, 22);
    // din_valid low 3 cycles in row 2 LOAD: done in cycle 25.
    run_seq(2, 3, -1, -1, 0, 27, 25);
    // start during PULSE (cycle 4) and during DONE (cycle 22) is ignored.
    run_seq(-1, 0, 4, 22, 0, 26, 22);
    // Reset while wl=0100 (cycle 14): everything clears, no done.
    run_seq(-1, 0, -1, -1, 14, 20, 0);
    // A fresh start reruns the whole bank from row 0.
    run_seq(-1, 0, -1, -1, 0, 24, 22);

    // ROWS=2, WL_PULSE=1: done in cycle 10.
    done2_at = 0;
    start2   = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      model(c, 2, 1, -1, 0, ph, r);
      start2 = 1'b0;
      din2   = words[r];
      if (done2 && done2_at == 0) done2_at = c;
      check($sformatf("d2_c%0d_wl", c), 32'(wl2), (ph == PhPulse) ? (32'd1 << r) : 32'd0);
      check($sformatf("d2_c%0d_bl", c), 32'(bl2),
            (ph >= PhSetup && ph <= PhHold) ? 32'(words[r]) : 32'd0);
      check($sformatf("d2_c%0d_done", c), 32'(done2), 32'(ph == PhDone));
    end
    check("d2_done_cycle", 32'(done2_at), 32'd10);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
